// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch memory block.
package ifetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    localparam logic [8:0] HALT_OP_DEFAULT = 9'b1_1111_1111;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: synchronous write port and a registered read port.
// Only the read register is reset; the array keeps its contents.
module inst_mem_array
    import ifetch_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q, rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // The read register holds its word whenever no read is requested.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch_mem.sv
// Writable instruction memory with internal fetch PC, stall, jump,
// PC-relative branch with squash, and halt-opcode detection.
module inst_fetch_mem
    import ifetch_pkg::*;
#(
    parameter int            IW      = 8,
    parameter int            DW      = 9,
    parameter logic [DW-1:0] HALT_OP = DW'(HALT_OP_DEFAULT)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          LoadEn,
    input  logic [IW-1:0] LoadAddr,
    input  logic [DW-1:0] LoadData,
    input  logic          Start,
    input  logic [IW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          Jump,
    input  logic [IW-1:0] JumpTarget,
    input  logic          BranchRel,
    input  logic [IW-1:0] BranchOffset,
    output logic [DW-1:0] InstOut,
    output logic          InstValid,
    output logic [IW-1:0] PcOut,
    output logic          Halted
);

    fetch_state_e  state_q, state_d;
    logic [IW-1:0] fpc_q, fpc_d;
    logic [IW-1:0] pc_q, pc_d;
    logic          valid_q, valid_d;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_rdata;
    logic [IW-1:0] branch_target;

    // An IW-bit add is the same as sign-extending the offset and wrapping.
    assign branch_target = pc_q + BranchOffset;
    assign mem_we        = LoadEn && (state_q != RUN);

    inst_mem_array #(
        .AW (IW),
        .DW (DW)
    ) u_mem (
        .clk   (Clk),
        .rst_n (Reset_n),
        .we    (mem_we),
        .waddr (LoadAddr),
        .wdata (LoadData),
        .re    (mem_re),
        .raddr (fpc_q),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        mem_re  = 1'b0;
        case (state_q)
            IDLE, HALT: begin
                if (Start) begin
                    fpc_d   = StartAddr;
                    state_d = RUN;
                    valid_d = 1'b0;
                end
            end
            RUN: begin
                // Halt outranks redirects; a redirect squashes the sequential fetch.
                if (!Stall) begin
                    if (valid_q && (mem_rdata == HALT_OP)) begin
                        state_d = HALT;
                        valid_d = 1'b0;
                    end else if (valid_q && (Jump || BranchRel)) begin
                        fpc_d   = Jump ? JumpTarget : branch_target;
                        valid_d = 1'b0;
                    end else begin
                        mem_re  = 1'b1;
                        pc_d    = fpc_q;
                        valid_d = 1'b1;
                        fpc_d   = fpc_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            fpc_q   <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign InstOut   = mem_rdata;
    assign InstValid = valid_q;
    assign PcOut     = pc_q;
    assign Halted    = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Directed bench for inst_fetch_mem: one table of per-cycle vectors plus
// a hand-written asynchronous-reset sequence.
module tb_inst_fetch_mem;

    localparam int IW = 8;
    localparam int DW = 9;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          LoadEn = 1'b0;
    logic [IW-1:0] LoadAddr = '0;
    logic [DW-1:0] LoadData = '0;
    logic          Start = 1'b0;
    logic [IW-1:0] StartAddr = '0;
    logic          Stall = 1'b0;
    logic          Jump = 1'b0;
    logic [IW-1:0] JumpTarget = '0;
    logic          BranchRel = 1'b0;
    logic [IW-1:0] BranchOffset = '0;
    logic [DW-1:0] InstOut;
    logic          InstValid;
    logic [IW-1:0] PcOut;
    logic          Halted;

    inst_fetch_mem #(.IW(IW), .DW(DW)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .LoadEn       (LoadEn),
        .LoadAddr     (LoadAddr),
        .LoadData     (LoadData),
        .Start        (Start),
        .StartAddr    (StartAddr),
        .Stall        (Stall),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .BranchRel    (BranchRel),
        .BranchOffset (BranchOffset),
        .InstOut      (InstOut),
        .InstValid    (InstValid),
        .PcOut        (PcOut),
        .Halted       (Halted)
    );

    always #5 Clk = ~Clk;

    typedef enum int {NOP, LOAD, START, STALL, JUMP, BR, JB, LDST} op_e;

    typedef struct {
        op_e           op;
        logic [IW-1:0] a;
        logic [DW-1:0] d;
        logic          ev;
        logic          eh;
        logic          chk;
        logic [DW-1:0] einst;
        logic [IW-1:0] epc;
    } vec_t;

    vec_t vt[$];
    int   checks = 0;
    int   errors = 0;

    function automatic vec_t mk(op_e op, logic [IW-1:0] a, logic [DW-1:0] d, logic ev,
                                logic eh, logic chk, logic [DW-1:0] einst, logic [IW-1:0] epc);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.ev = ev; v.eh = eh;
        v.chk = chk; v.einst = einst; v.epc = epc;
        return v;
    endfunction

    // Outputs still at their reset values while IDLE.
    function automatic vec_t idle(op_e op, logic [IW-1:0] a, logic [DW-1:0] d);
        return mk(op, a, d, 1'b0, 1'b0, 1'b1, '0, '0);
    endfunction

    // Valid word presented.
    function automatic vec_t run(op_e op, logic [IW-1:0] a, logic [DW-1:0] inst, logic [IW-1:0] pc);
        return mk(op, a, '0, 1'b1, 1'b0, 1'b1, inst, pc);
    endfunction

    // Squash / start cycle: nothing valid, word content not checked.
    function automatic vec_t sq(op_e op, logic [IW-1:0] a, logic [DW-1:0] d);
        return mk(op, a, d, 1'b0, 1'b0, 1'b0, '0, '0);
    endfunction

    // Halted, holding the halt word and its address.
    function automatic vec_t hlt(op_e op, logic [IW-1:0] a, logic [DW-1:0] d,
                                 logic [DW-1:0] inst, logic [IW-1:0] pc);
        return mk(op, a, d, 1'b0, 1'b1, 1'b1, inst, pc);
    endfunction

    task automatic drive(op_e op, logic [IW-1:0] a, logic [DW-1:0] d);
        LoadEn       = (op == LOAD) || (op == LDST);
        LoadAddr     = a;
        LoadData     = d;
        Start        = (op == START) || (op == LDST);
        StartAddr    = a;
        Stall        = (op == STALL);
        Jump         = (op == JUMP) || (op == JB);
        JumpTarget   = a;
        BranchRel    = (op == BR) || (op == JB);
        BranchOffset = (op == JB) ? d[IW-1:0] : a;
    endtask

    task automatic check(string name, logic ev, logic eh, logic chk,
                         logic [DW-1:0] einst, logic [IW-1:0] epc);
        checks++;
        if (InstValid !== ev || Halted !== eh ||
            (chk && (InstOut !== einst || PcOut !== epc))) begin
            errors++;
            $display("FAIL %s: got valid=%b halted=%b inst=%h pc=%h, want valid=%b halted=%b inst=%h pc=%h%s",
                     name, InstValid, Halted, InstOut, PcOut, ev, eh, einst, epc,
                     chk ? "" : " (inst/pc not checked)");
        end
    endtask

    initial begin
        // Program load in IDLE
        vt.push_back(idle(LOAD, 8'h00, 9'h10C));
        vt.push_back(idle(LOAD, 8'h01, 9'h13C));
        vt.push_back(idle(LOAD, 8'h02, 9'h19C));
        vt.push_back(idle(LOAD, 8'h03, 9'h10E));
        vt.push_back(idle(LOAD, 8'h04, 9'h020));
        vt.push_back(idle(LOAD, 8'h05, 9'h021));
        vt.push_back(idle(LOAD, 8'h06, 9'h022));
        vt.push_back(idle(LOAD, 8'h40, 9'h088));
        vt.push_back(idle(LOAD, 8'h41, 9'h089));
        vt.push_back(idle(LOAD, 8'h80, 9'h1FF));
        // Start, sequential fetch, stall
        vt.push_back(idle(START, 8'h00, 9'h000));
        vt.push_back(run(NOP,   8'h00, 9'h10C, 8'h00));
        vt.push_back(run(NOP,   8'h00, 9'h13C, 8'h01));
        vt.push_back(run(STALL, 8'h00, 9'h13C, 8'h01));
        vt.push_back(run(STALL, 8'h00, 9'h13C, 8'h01));
        vt.push_back(run(STALL, 8'h00, 9'h13C, 8'h01));
        vt.push_back(run(NOP,   8'h00, 9'h19C, 8'h02));
        vt.push_back(run(NOP,   8'h00, 9'h10E, 8'h03));
        vt.push_back(run(NOP,   8'h00, 9'h020, 8'h04));
        vt.push_back(run(NOP,   8'h00, 9'h021, 8'h05));
        // Branch -2 from PcOut=5
        vt.push_back(sq(BR, 8'hFE, 9'h000));
        vt.push_back(run(NOP, 8'h00, 9'h10E, 8'h03));
        vt.push_back(run(NOP, 8'h00, 9'h020, 8'h04));
        // Jump and branch together: jump target wins
        vt.push_back(sq(JB, 8'h40, 9'h001));
        vt.push_back(run(NOP, 8'h00, 9'h088, 8'h40));
        vt.push_back(run(NOP, 8'h00, 9'h089, 8'h41));
        // Jump to 2; jump during the squash cycle is ignored; jump at PcOut=2
        vt.push_back(sq(JUMP, 8'h02, 9'h000));
        vt.push_back(run(JUMP, 8'h10, 9'h19C, 8'h02));
        vt.push_back(sq(JUMP, 8'h40, 9'h000));
        vt.push_back(run(NOP, 8'h00, 9'h088, 8'h40));
        // Load during RUN must not write
        vt.push_back(mk(LOAD, 8'h41, 9'h1FF, 1'b1, 1'b0, 1'b1, 9'h089, 8'h41));
        vt.push_back(sq(JUMP, 8'h41, 9'h000));
        vt.push_back(run(NOP, 8'h00, 9'h089, 8'h41));
        // Halt at 0x80
        vt.push_back(sq(JUMP, 8'h80, 9'h000));
        vt.push_back(run(NOP, 8'h00, 9'h1FF, 8'h80));
        vt.push_back(hlt(NOP,  8'h00, 9'h000, 9'h1FF, 8'h80));
        vt.push_back(hlt(JUMP, 8'h00, 9'h000, 9'h1FF, 8'h80));
        vt.push_back(hlt(LOAD, 8'h04, 9'h1FF, 9'h1FF, 8'h80));
        // Restart from HALT, halt at 4 with jump+branch asserted
        vt.push_back(sq(START, 8'h00, 9'h000));
        vt.push_back(run(NOP, 8'h00, 9'h10C, 8'h00));
        vt.push_back(run(NOP, 8'h00, 9'h13C, 8'h01));
        vt.push_back(run(NOP, 8'h00, 9'h19C, 8'h02));
        vt.push_back(run(NOP, 8'h00, 9'h10E, 8'h03));
        vt.push_back(run(NOP, 8'h00, 9'h1FF, 8'h04));
        vt.push_back(hlt(JB,  8'h10, 9'h001, 9'h1FF, 8'h04));
        vt.push_back(hlt(NOP, 8'h00, 9'h000, 9'h1FF, 8'h04));
        // Load and start at 0xFF together, then wrap to 0
        vt.push_back(sq(LDST, 8'hFF, 9'h055));
        vt.push_back(run(NOP, 8'h00, 9'h055, 8'hFF));
        vt.push_back(run(NOP, 8'h00, 9'h10C, 8'h00));
        vt.push_back(run(NOP, 8'h00, 9'h13C, 8'h01));
        vt.push_back(run(NOP, 8'h00, 9'h19C, 8'h02));

        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("reset_state", 1'b0, 1'b0, 1'b1, '0, '0);
        Reset_n = 1'b1;

        foreach (vt[i]) begin
            drive(vt[i].op, vt[i].a, vt[i].d);
            @(posedge Clk);
            #1;
            check($sformatf("vec%0d", i), vt[i].ev, vt[i].eh, vt[i].chk, vt[i].einst, vt[i].epc);
        end

        // Asynchronous reset mid-run, away from any clock edge
        drive(NOP, '0, '0);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset", 1'b0, 1'b0, 1'b1, '0, '0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("idle_after_reset", 1'b0, 1'b0, 1'b1, '0, '0);

        // Memory survives reset
        drive(START, 8'h00, '0);
        @(posedge Clk);
        #1;
        check("restart", 1'b0, 1'b0, 1'b1, '0, '0);
        drive(NOP, '0, '0);
        @(posedge Clk);
        #1;
        check("kept_w0", 1'b1, 1'b0, 1'b1, 9'h10C, 8'h00);
        @(posedge Clk);
        #1;
        check("kept_w1", 1'b1, 1'b0, 1'b1, 9'h13C, 8'h01);
        @(posedge Clk);
        #1;
        check("kept_w2", 1'b1, 1'b0, 1'b1, 9'h19C, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
